// File: rtl/int_iq1_issue_queue.sv
`default_nettype none
// ============================================================================
// Module  : int_iq1_issue_queue
// Brief   : 8-entry integer issue queue (IQ1) with tag wakeup and an age matrix
//           that selects the oldest ready entry into a registered issue stage.
//           Optional build macro: INTIQ1_DISPATCH_BYPASS_EN (dispatch-to-issue bypass).
// Revision: 1.0 - initial release
// ============================================================================
module int_iq1_issue_queue #(
    parameter int PAYW  = 32,
    parameter int TAGW  = 6,
    parameter int SLOTW = 5,
    parameter int DEPTH = 8
) (
    input  logic                Clk,
    input  logic                Rest,
    // dispatch
    input  logic                DispValid,
    output logic                DispReady,
    input  logic [PAYW-1:0]     DispPay,
    input  logic [TAGW-1:0]     DispSrc1Tag,
    input  logic [TAGW-1:0]     DispSrc2Tag,
    input  logic                DispSrc1Rdy,
    input  logic                DispSrc2Rdy,
    input  logic [TAGW-1:0]     DispDst,
    // free list
    input  logic [SLOTW-1:0]    FlSlot,
    input  logic                FlEmpty,
    output logic                FlRead,
    output logic                FlFreeValid,
    output logic [SLOTW-1:0]    FlFreeSlot,
    output logic                FlClean,
    // wakeup
    input  logic [1:0]          WkValid,
    input  logic [2*TAGW-1:0]   WkTag,
    input  logic                Flush,
    // issue
    output logic                IssValid,
    input  logic                IssReady,
    output logic [PAYW-1:0]     IssPay,
    output logic [TAGW-1:0]     IssSrc1Tag,
    output logic [TAGW-1:0]     IssSrc2Tag,
    output logic [TAGW-1:0]     IssDst
);

    localparam int IDXW = SLOTW - 2;

    // entry state
    logic [DEPTH-1:0] r_v;
    logic [DEPTH-1:0] r_s1rdy;
    logic [DEPTH-1:0] r_s2rdy;
    logic [DEPTH-1:0] r_old [DEPTH];
    logic [PAYW-1:0]  r_pay   [DEPTH];
    logic [TAGW-1:0]  r_s1tag [DEPTH];
    logic [TAGW-1:0]  r_s2tag [DEPTH];
    logic [TAGW-1:0]  r_dst   [DEPTH];

    logic [DEPTH-1:0] w_elig;
    logic [DEPTH-1:0] w_sel;
    logic [DEPTH-1:0] w_wk1;
    logic [DEPTH-1:0] w_wk2;
    logic [DEPTH-1:0] w_leave;
    logic [DEPTH-1:0] w_disp_oh;
    logic [DEPTH-1:0] w_row;
    logic [IDXW-1:0]  w_sel_idx;
    logic [IDXW-1:0]  w_disp_idx;
    logic             w_adv;
    logic             w_any_sel;
    logic             w_issue;
    logic             w_disp;
    logic             w_disp_s1rdy;
    logic             w_disp_s2rdy;
    logic             w_byp;
    logic             w_unused_slot_lsb;

    function automatic logic f_wake(input logic [TAGW-1:0]   tag,
                                    input logic [1:0]        wkv,
                                    input logic [2*TAGW-1:0] wkt);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (wkv[k] && (wkt[k*TAGW +: TAGW] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    assign w_elig = r_v & r_s1rdy & r_s2rdy;

    // An entry wins when no older entry is also eligible.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign w_sel[gi] = w_elig[gi] && ((r_old[gi] & w_elig) == '0);
            assign w_wk1[gi] = f_wake(r_s1tag[gi], WkValid, WkTag);
            assign w_wk2[gi] = f_wake(r_s2tag[gi], WkValid, WkTag);
        end
    endgenerate

    always_comb begin
        w_sel_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_sel[i]) begin
                w_sel_idx = IDXW'(i);
            end
        end
    end

    assign w_adv     = !IssValid || IssReady;
    assign w_any_sel = |w_sel;
    assign w_issue   = w_adv && w_any_sel && !Flush;
    assign w_leave   = w_sel & {DEPTH{w_issue}};

    assign w_disp_idx   = FlSlot[SLOTW-1:2];
    assign w_disp_s1rdy = DispSrc1Rdy || f_wake(DispSrc1Tag, WkValid, WkTag);
    assign w_disp_s2rdy = DispSrc2Rdy || f_wake(DispSrc2Tag, WkValid, WkTag);
    assign w_unused_slot_lsb = ^FlSlot[1:0];

`ifdef INTIQ1_DISPATCH_BYPASS_EN
    // Ready uop goes straight to the issue register when nothing queued can issue.
    assign w_byp = DispValid && !Flush && w_adv && (w_elig == '0)
                && w_disp_s1rdy && w_disp_s2rdy;
`else
    assign w_byp = 1'b0;
`endif

    assign DispReady = (!FlEmpty && !Flush) || w_byp;
    assign FlRead    = DispValid && DispReady && !w_byp;
    assign FlClean   = Flush;
    assign w_disp    = FlRead;

    assign w_disp_oh = w_disp ? ({{(DEPTH-1){1'b0}}, 1'b1} << w_disp_idx) : '0;
    // New entry is younger than every survivor; it never ages against itself.
    assign w_row     = r_v & ~w_leave & ~w_disp_oh;

    // payload storage: qualified by the valid bits, so no reset needed
    always_ff @(posedge Clk) begin
        if (w_disp) begin
            r_pay[w_disp_idx]   <= DispPay;
            r_s1tag[w_disp_idx] <= DispSrc1Tag;
            r_s2tag[w_disp_idx] <= DispSrc2Tag;
            r_dst[w_disp_idx]   <= DispDst;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rest) begin
            r_v         <= '0;
            r_s1rdy     <= '0;
            r_s2rdy     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_old[i] <= '0;
            end
            IssValid    <= 1'b0;
            IssPay      <= '0;
            IssSrc1Tag  <= '0;
            IssSrc2Tag  <= '0;
            IssDst      <= '0;
            FlFreeValid <= 1'b0;
            FlFreeSlot  <= '0;
        end else if (Flush) begin
            r_v         <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_old[i] <= '0;
            end
            IssValid    <= 1'b0;
            FlFreeValid <= 1'b0;
        end else begin
            FlFreeValid <= w_issue;
            if (w_issue) begin
                FlFreeSlot <= {w_sel_idx, 2'b00};
            end

            if (w_adv) begin
                if (w_any_sel) begin
                    IssValid   <= 1'b1;
                    IssPay     <= r_pay[w_sel_idx];
                    IssSrc1Tag <= r_s1tag[w_sel_idx];
                    IssSrc2Tag <= r_s2tag[w_sel_idx];
                    IssDst     <= r_dst[w_sel_idx];
                end else if (w_byp) begin
                    IssValid   <= 1'b1;
                    IssPay     <= DispPay;
                    IssSrc1Tag <= DispSrc1Tag;
                    IssSrc2Tag <= DispSrc2Tag;
                    IssDst     <= DispDst;
                end else begin
                    IssValid   <= 1'b0;
                end
            end

            r_v <= (r_v & ~w_leave) | w_disp_oh;

            for (int i = 0; i < DEPTH; i++) begin
                if (w_disp_oh[i]) begin
                    r_s1rdy[i] <= w_disp_s1rdy;
                    r_s2rdy[i] <= w_disp_s2rdy;
                    r_old[i]   <= w_row;
                end else begin
                    r_s1rdy[i] <= r_s1rdy[i] | w_wk1[i];
                    r_s2rdy[i] <= r_s2rdy[i] | w_wk2[i];
                    if (w_disp) begin
                        r_old[i][w_disp_idx] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_int_iq1_issue_queue.sv
`default_nettype none
// ============================================================================
// Module  : tb_int_iq1_issue_queue
// Brief   : Scoreboard bench for int_iq1_issue_queue: directed scenarios plus
//           randomized traffic against a sequence-number age model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_int_iq1_issue_queue;

    localparam int PAYW  = 32;
    localparam int TAGW  = 6;
    localparam int SLOTW = 5;

    logic              Clk = 1'b0;
    logic              Rest;
    logic              DispValid;
    logic              DispReady;
    logic [PAYW-1:0]   DispPay;
    logic [TAGW-1:0]   DispSrc1Tag, DispSrc2Tag, DispDst;
    logic              DispSrc1Rdy, DispSrc2Rdy;
    logic [SLOTW-1:0]  FlSlot;
    logic              FlEmpty;
    logic              FlRead;
    logic              FlFreeValid;
    logic [SLOTW-1:0]  FlFreeSlot;
    logic              FlClean;
    logic [1:0]        WkValid;
    logic [2*TAGW-1:0] WkTag;
    logic              Flush;
    logic              IssValid;
    logic              IssReady;
    logic [PAYW-1:0]   IssPay;
    logic [TAGW-1:0]   IssSrc1Tag, IssSrc2Tag, IssDst;

    always #5 Clk = ~Clk;

    int_iq1_issue_queue #(.PAYW(PAYW), .TAGW(TAGW), .SLOTW(SLOTW), .DEPTH(8)) dut (
        .Clk(Clk), .Rest(Rest),
        .DispValid(DispValid), .DispReady(DispReady), .DispPay(DispPay),
        .DispSrc1Tag(DispSrc1Tag), .DispSrc2Tag(DispSrc2Tag),
        .DispSrc1Rdy(DispSrc1Rdy), .DispSrc2Rdy(DispSrc2Rdy), .DispDst(DispDst),
        .FlSlot(FlSlot), .FlEmpty(FlEmpty), .FlRead(FlRead),
        .FlFreeValid(FlFreeValid), .FlFreeSlot(FlFreeSlot), .FlClean(FlClean),
        .WkValid(WkValid), .WkTag(WkTag), .Flush(Flush),
        .IssValid(IssValid), .IssReady(IssReady), .IssPay(IssPay),
        .IssSrc1Tag(IssSrc1Tag), .IssSrc2Tag(IssSrc2Tag), .IssDst(IssDst)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [PAYW-1:0]  pay;
        logic [TAGW-1:0]  s1, s2, dst;
        logic [SLOTW-1:0] slot;
    } exp_t;
    exp_t expq[$];

    // Reference model: an unordered pool of entries, age = dispatch sequence number.
    bit              mv[8];
    bit              mr1[8], mr2[8];
    logic [PAYW-1:0] mpay[8];
    logic [TAGW-1:0] ms1[8], ms2[8], mdst[8];
    int              mseq[8];
    int              seqctr = 0;
    bit              miv = 0;
    logic [PAYW-1:0] m_iss_pay = '0;
    bit              mfree_pend = 0;
    logic [SLOTW-1:0] mfree_slot = '0;

    function automatic bit woke(input logic [TAGW-1:0] t);
        return (WkValid[0] && WkTag[TAGW-1:0] == t) || (WkValid[1] && WkTag[2*TAGW-1:TAGW] == t);
    endfunction

    task automatic model_step();
        exp_t e;
        int pick, d;
        if (Rest) begin
            for (int i = 0; i < 8; i++) mv[i] = 0;
            miv = 0; m_iss_pay = '0; mfree_pend = 0;
            expq.delete();
            return;
        end
        mfree_pend = 0;
        if (Flush) begin
            for (int i = 0; i < 8; i++) mv[i] = 0;
            miv = 0;
            return;
        end
        pick = -1;
        for (int i = 0; i < 8; i++) begin
            if (mv[i] && mr1[i] && mr2[i] && (pick < 0 || mseq[i] < mseq[pick])) pick = i;
        end
        if (!miv || IssReady) begin
            if (pick >= 0) begin
                e.pay = mpay[pick]; e.s1 = ms1[pick]; e.s2 = ms2[pick]; e.dst = mdst[pick];
                e.slot = SLOTW'(pick * 4);
                expq.push_back(e);
                mv[pick] = 0; miv = 1; m_iss_pay = e.pay;
                mfree_pend = 1; mfree_slot = e.slot;
            end else begin
                miv = 0;
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (mv[i]) begin
                mr1[i] = mr1[i] || woke(ms1[i]);
                mr2[i] = mr2[i] || woke(ms2[i]);
            end
        end
        if (DispValid && !FlEmpty) begin
            d = int'(FlSlot) / 4;
            chk("disp_slot_free", 64'(mv[d]), 64'd0);
            mv[d] = 1; mpay[d] = DispPay; ms1[d] = DispSrc1Tag; ms2[d] = DispSrc2Tag;
            mdst[d] = DispDst;
            mr1[d] = DispSrc1Rdy || woke(DispSrc1Tag);
            mr2[d] = DispSrc2Rdy || woke(DispSrc2Tag);
            mseq[d] = seqctr++;
        end
    endtask

    // monitor: pops the scoreboard whenever the DUT returns a slot
    always @(negedge Clk) begin
        exp_t e;
        if (FlFreeValid) begin
            if (expq.size() == 0) begin
                chk("unexpected_issue", 64'd1, 64'd0);
            end else begin
                e = expq.pop_front();
                chk("sb_iss_valid", 64'(IssValid), 64'd1);
                chk("sb_pay",  64'(IssPay), 64'(e.pay));
                chk("sb_src1", 64'(IssSrc1Tag), 64'(e.s1));
                chk("sb_src2", 64'(IssSrc2Tag), 64'(e.s2));
                chk("sb_dst",  64'(IssDst), 64'(e.dst));
                chk("sb_free_slot", 64'(FlFreeSlot), 64'(e.slot));
            end
        end
        chk("free_valid", 64'(FlFreeValid), 64'(mfree_pend));
        chk("iss_valid", 64'(IssValid), 64'(miv));
        if (miv) chk("iss_hold_pay", 64'(IssPay), 64'(m_iss_pay));
        chk("fl_read", 64'(FlRead), 64'(DispValid && !FlEmpty && !Flush));
        chk("disp_ready", 64'(DispReady), 64'(!FlEmpty && !Flush));
        chk("fl_clean", 64'(FlClean), 64'(Flush));
    end

    task automatic tick();
        @(posedge Clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        DispValid = 0; Flush = 0; WkValid = 2'b00; WkTag = '0; FlEmpty = 0;
        DispPay = '0; DispSrc1Tag = '0; DispSrc2Tag = '0; DispDst = '0;
        DispSrc1Rdy = 0; DispSrc2Rdy = 0; FlSlot = '0;
    endtask

    task automatic disp(input logic [PAYW-1:0] pay, input logic [SLOTW-1:0] slot,
                        input logic [TAGW-1:0] t1, input logic r1,
                        input logic [TAGW-1:0] t2, input logic r2);
        DispValid = 1; DispPay = pay; FlSlot = slot; FlEmpty = 0;
        DispSrc1Tag = t1; DispSrc1Rdy = r1; DispSrc2Tag = t2; DispSrc2Rdy = r2;
        DispDst = TAGW'(pay[5:0] ^ 6'h2a);
    endtask

    task automatic drain(input int n);
        idle(); IssReady = 1;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int free_list[$];
        Rest = 1; IssReady = 1; idle();
        tick(); tick();
        Rest = 0;
        chk("rst_iss_valid", 64'(IssValid), 64'd0);
        chk("rst_iss_pay", 64'(IssPay), 64'd0);
        chk("rst_iss_dst", 64'(IssDst), 64'd0);
        chk("rst_free_valid", 64'(FlFreeValid), 64'd0);
        chk("rst_free_slot", 64'(FlFreeSlot), 64'd0);

        // basic two-cycle issue
        disp(32'h11, 5'd8, 6'd1, 1, 6'd2, 1);
        #1 chk("t1_flread", 64'(FlRead), 64'd1);
        tick(); idle(); tick();
        chk("t1_iss_valid", 64'(IssValid), 64'd1);
        chk("t1_iss_pay", 64'(IssPay), 64'h11);
        chk("t1_free_valid", 64'(FlFreeValid), 64'd1);
        chk("t1_free_slot", 64'(FlFreeSlot), 64'd8);
        drain(3);

        // younger ready entry overtakes older waiting one
        disp(32'hA, 5'd0, 6'd5, 0, 6'd7, 1); tick();
        disp(32'hB, 5'd4, 6'd3, 1, 6'd4, 1); tick();
        idle(); tick();
        chk("t2_first_pay", 64'(IssPay), 64'hB);
        WkValid = 2'b01; WkTag = {6'd0, 6'd5}; tick();
        idle(); tick();
        chk("t2_second_pay", 64'(IssPay), 64'hA);
        drain(3);

        // backpressure then oldest-first
        IssReady = 0;
        disp(32'hC12, 5'd12, 6'd1, 1, 6'd1, 1); tick();
        disp(32'hC00, 5'd0,  6'd1, 1, 6'd1, 1); tick();
        disp(32'hC20, 5'd20, 6'd1, 1, 6'd1, 1); tick();
        idle(); tick(); tick();
        chk("t3_hold_pay", 64'(IssPay), 64'hC12);
        chk("t3_hold_slot", 64'(FlFreeSlot), 64'd12);
        drain(5);

        // free list empty blocks dispatch
        disp(32'hDEAD, 5'd16, 6'd1, 1, 6'd1, 1); FlEmpty = 1;
        #1 chk("t4_disp_ready", 64'(DispReady), 64'd0);
        chk("t4_flread", 64'(FlRead), 64'd0);
        tick();
        drain(3);
        chk("t4_no_issue", 64'(IssValid), 64'd0);

        // flush with five waiting entries and a held output
        IssReady = 0;
        for (int i = 0; i < 6; i++) begin
            disp(32'hF0 + 32'(i), SLOTW'(i * 4), 6'd1, 1, 6'd1, 1); tick();
        end
        idle(); Flush = 1;
        #1 chk("t5_fl_clean", 64'(FlClean), 64'd1);
        tick();
        Flush = 0;
        chk("t5_iss_valid", 64'(IssValid), 64'd0);
        chk("t5_free_valid", 64'(FlFreeValid), 64'd0);
        drain(4);
        chk("t5_still_empty", 64'(IssValid), 64'd0);

        // same-cycle wakeup at dispatch
        disp(32'h66, 5'd24, 6'd3, 1, 6'd9, 0);
        WkValid = 2'b10; WkTag = {6'd9, 6'd0};
        tick(); idle(); tick();
        chk("t6_iss_valid", 64'(IssValid), 64'd1);
        chk("t6_iss_pay", 64'(IssPay), 64'h66);
        drain(3);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            free_list.delete();
            for (int i = 0; i < 8; i++) begin
                if (!mv[i] && !(mfree_pend && mfree_slot == SLOTW'(i * 4))) free_list.push_back(i);
            end
            DispValid   = ($urandom_range(0, 99) < 60);
            FlEmpty     = (free_list.size() == 0) || ($urandom_range(0, 9) == 0);
            FlSlot      = (free_list.size() != 0)
                        ? SLOTW'(free_list[$urandom_range(0, free_list.size() - 1)] * 4) : 5'd0;
            DispPay     = $urandom;
            DispSrc1Tag = TAGW'($urandom_range(0, 7));
            DispSrc2Tag = TAGW'($urandom_range(0, 7));
            DispSrc1Rdy = ($urandom_range(0, 1) == 1);
            DispSrc2Rdy = ($urandom_range(0, 1) == 1);
            DispDst     = TAGW'($urandom_range(0, 63));
            WkValid     = 2'($urandom_range(0, 3));
            WkTag       = {TAGW'($urandom_range(0, 7)), TAGW'($urandom_range(0, 7))};
            IssReady    = ($urandom_range(0, 9) < 7);
            Flush       = ($urandom_range(0, 199) == 0);
            Rest        = (n == 1500);
            tick();
            if (n == 1500) begin
                chk("mid_rst_pay", 64'(IssPay), 64'd0);
                chk("mid_rst_free_slot", 64'(FlFreeSlot), 64'd0);
                Rest = 0;
            end
        end
        idle(); Flush = 1; tick();
        drain(4);
        chk("sb_drained", 64'(expq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
